// File: rtl/timer_pkg.sv
// Shared types, seven-segment table and BCD helpers for the countdown timer.
package timer_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned MAX_W      = 4 * MAX_DIGITS;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  // Active-low segments, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Subtract one with a digit-to-digit borrow chain; 0 wraps to 9.
  function automatic logic [MAX_W-1:0] bcd_decrement(input logic [MAX_W-1:0] v);
    logic [MAX_W-1:0] r;
    logic             borrow;
    logic [3:0]       d;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Force any non-decimal nibble to 9.
  function automatic logic [MAX_W-1:0] bcd_clamp(input logic [MAX_W-1:0] v);
    logic [MAX_W-1:0] r;
    r = v;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD digit plus blank request to active-low seven-segment pattern.
module seven_seg_decoder
  import timer_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0:    o_seg_c = SEG_0;
        4'd1:    o_seg_c = SEG_1;
        4'd2:    o_seg_c = SEG_2;
        4'd3:    o_seg_c = SEG_3;
        4'd4:    o_seg_c = SEG_4;
        4'd5:    o_seg_c = SEG_5;
        4'd6:    o_seg_c = SEG_6;
        4'd7:    o_seg_c = SEG_7;
        4'd8:    o_seg_c = SEG_8;
        4'd9:    o_seg_c = SEG_9;
        default: o_seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with pause, optional auto-reload and a
// time-multiplexed seven-segment display driver.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 2,
  parameter int unsigned REFRESH_BITS  = 16,
  parameter int unsigned AUTO_RELOAD   = 0,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    Reset_n,
  input  logic                    Start_Timer,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Pause,
  input  logic                    OneHz,
  output logic [4*NUM_DIGITS-1:0] Count,
  output logic                    Running,
  output logic                    Expired,
  output logic                    Expired_Pulse,
  output logic [NUM_DIGITS-1:0]   Anode_Activate,
  output logic [6:0]              LED_out
);

  localparam int unsigned CNT_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]        r_count, r_preload;
  logic                    r_s1, r_s2, r_s3;
  logic                    r_running, r_expired, r_pulse;
  logic [REFRESH_BITS-1:0] r_presc;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_led;

  logic             w_tick, w_load, w_dec, w_expire, w_at_one;
  logic [CNT_W-1:0] w_cnt_dec, w_value_clamped;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [6:0]       w_seg_c;

  assign w_tick          = r_s2 & ~r_s3;
  assign w_at_one        = (r_count == CNT_W'(1));
  assign w_cnt_dec       = CNT_W'(bcd_decrement(MAX_W'(r_count)));
  assign w_value_clamped = CNT_W'(bcd_clamp(MAX_W'(Value)));

  // OneHz synchroniser plus edge-detect flop
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= OneHz;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Start_Timer overrides everything; Pause outranks a tick
  always_comb begin
    w_state_nxt = r_state;
    if (Start_Timer) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_IDLE;
        ST_LOAD:    w_state_nxt = (r_preload == '0) ? ST_EXPIRED : ST_RUN;
        ST_RUN: begin
          if (Pause)                                       w_state_nxt = ST_PAUSE;
          else if (w_tick && w_at_one && AUTO_RELOAD == 0) w_state_nxt = ST_EXPIRED;
        end
        ST_PAUSE:   w_state_nxt = Pause ? ST_PAUSE : ST_RUN;
        ST_EXPIRED: w_state_nxt = ST_EXPIRED;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load   = Start_Timer;
    w_dec    = 1'b0;
    w_expire = 1'b0;
    if (!Start_Timer) begin
      w_dec    = (r_state == ST_RUN) && !Pause && w_tick;
      w_expire = (w_dec && w_at_one) ||
                 ((r_state == ST_LOAD) && (r_preload == '0));
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count   <= '0;
      r_preload <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      if (w_load) begin
        r_count   <= w_value_clamped;
        r_preload <= w_value_clamped;
      end else if (w_dec) begin
        if (w_at_one) r_count <= (AUTO_RELOAD != 0) ? r_preload : '0;
        else          r_count <= w_cnt_dec;
      end else if (w_state_nxt == ST_EXPIRED) begin
        r_count <= '0;
      end
      r_running <= (w_state_nxt == ST_RUN);
      r_expired <= (AUTO_RELOAD != 0) ? w_expire : (w_state_nxt == ST_EXPIRED);
      r_pulse   <= w_expire;
    end
  end

  // Display scan: index advances when the prescaler wraps
  always_comb begin
    w_idx_nxt = r_idx;
    if (&r_presc) begin
      w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Pick the digit for the upcoming index and decide leading-zero blanking
  always_comb begin
    logic z;
    w_digit = '0;
    w_blank = 1'b0;
    z       = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      z = z && (r_count[4*i +: 4] == 4'd0);
      if (w_idx_nxt == IDX_W'(i)) begin
        w_digit = r_count[4*i +: 4];
        w_blank = (BLANK_LEADING != 0) && (i != 0) && z;
      end
    end
  end

  seven_seg_decoder u_dec (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg_c (w_seg_c)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_anode <= ~NUM_DIGITS'(1);
      r_led   <= SEG_0;
    end else begin
      r_presc <= r_presc + REFRESH_BITS'(1);
      r_idx   <= w_idx_nxt;
      r_anode <= ~(NUM_DIGITS'(1) << w_idx_nxt);
      r_led   <= w_seg_c;
    end
  end

  assign Count          = r_count;
  assign Running        = r_running;
  assign Expired        = r_expired;
  assign Expired_Pulse  = r_pulse;
  assign Anode_Activate = r_anode;
  assign LED_out        = r_led;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: one non-reloading and one auto-reloading timer share stimulus.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n, start, pause, one_hz;
  logic [7:0] value;

  logic [7:0] c0, c1;
  logic       run0, run1, exp0, exp1, pul0, pul1;
  logic [1:0] an0, an1;
  logic [6:0] led0, led1;

  int n_checks = 0;
  int n_errors = 0;
  int n_pul0   = 0;
  int n_pul1   = 0;

  typedef struct packed {
    logic       sel;
    logic [7:0] cnt;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  bcd_countdown_timer #(
    .NUM_DIGITS(2), .REFRESH_BITS(2), .AUTO_RELOAD(0), .BLANK_LEADING(1)
  ) dut0 (
    .clk(clk), .Reset_n(rst_n), .Start_Timer(start), .Value(value),
    .Pause(pause), .OneHz(one_hz), .Count(c0), .Running(run0),
    .Expired(exp0), .Expired_Pulse(pul0), .Anode_Activate(an0), .LED_out(led0)
  );

  bcd_countdown_timer #(
    .NUM_DIGITS(2), .REFRESH_BITS(2), .AUTO_RELOAD(1), .BLANK_LEADING(1)
  ) dut1 (
    .clk(clk), .Reset_n(rst_n), .Start_Timer(start), .Value(value),
    .Pause(pause), .OneHz(one_hz), .Count(c1), .Running(run1),
    .Expired(exp1), .Expired_Pulse(pul1), .Anode_Activate(an1), .LED_out(led1)
  );

  // Each cycle a pulse is high adds one, so a clean expiry adds exactly one
  always @(posedge clk) begin
    if (pul0) n_pul0 <= n_pul0 + 1;
    if (pul1) n_pul1 <= n_pul1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    value = v;
    start = 1'b1;
    cycles(3);
    start = 1'b0;
    cycles(3);
  endtask

  task automatic tick_expect(input logic sel, input logic [7:0] exp, input string tag);
    sb_t e;
    sb_q.push_back({sel, exp});
    one_hz = 1'b1;
    cycles(6);
    one_hz = 1'b0;
    cycles(6);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(tag, e.sel ? 32'(c1) : 32'(c0), 32'(e.cnt));
    end
  endtask

  // Anode must hold for 4 clocks per digit; LED must match the lit digit
  task automatic scan(input string tag);
    logic [1:0] last;
    int         run_len;
    int         seen;
    logic [6:0] want;
    last    = an0;
    run_len = 0;
    seen    = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an0 != last) begin
        if (seen > 0) check({tag, "_anode_period"}, 32'(run_len), 32'd4);
        seen++;
        run_len = 0;
        last    = an0;
      end
      run_len++;
      if (an0 == 2'b10)      want = exp_seg(c0[3:0]);
      else if (an0 == 2'b01) want = (c0[7:4] == 4'd0) ? 7'b1111111 : exp_seg(c0[7:4]);
      else                   want = 7'bxxxxxxx;
      check({tag, "_led"}, 32'(led0), 32'(want));
    end
    check({tag, "_anode_toggles"}, 32'(seen), 32'd5);
  endtask

  initial begin
    int p0, p1;
    rst_n  = 1'b1;
    start  = 1'b0;
    pause  = 1'b0;
    one_hz = 1'b0;
    value  = 8'h00;
    #2 rst_n = 1'b0;
    cycles(3);
    check("rst_count",   32'(c0),   32'h00);
    check("rst_expired", 32'(exp0), 32'd0);
    check("rst_pulse",   32'(pul0), 32'd0);
    check("rst_running", 32'(run0), 32'd0);
    check("rst_anode",   32'(an0),  32'b10);
    check("rst_led",     32'(led0), 32'b0000001);
    check("rst_anode1",  32'(an1),  32'b10);
    rst_n = 1'b1;
    cycles(2);

    // Asynchronous reset in the middle of a count
    load(8'h05);
    check("pre_reset_count",   32'(c0),   32'h05);
    check("pre_reset_running", 32'(run0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count",   32'(c0),   32'h00);
    check("async_rst_expired", 32'(exp0), 32'd0);
    check("async_rst_anode",   32'(an0),  32'b10);
    check("async_rst_led",     32'(led0), 32'b0000001);
    cycles(1);
    rst_n = 1'b1;
    cycles(2);

    // Basic countdown to expiry
    p0 = n_pul0;
    load(8'h03);
    check("load_03", 32'(c0), 32'h03);
    tick_expect(1'b0, 8'h02, "cd_02");
    tick_expect(1'b0, 8'h01, "cd_01");
    tick_expect(1'b0, 8'h00, "cd_00");
    check("cd_expired",    32'(exp0),       32'd1);
    check("cd_not_run",    32'(run0),       32'd0);
    check("cd_pulse_once", 32'(n_pul0 - p0), 32'd1);
    tick_expect(1'b0, 8'h00, "cd_hold_00");
    check("cd_expired_hold", 32'(exp0), 32'd1);

    // Borrow across digits and clamp of non-decimal nibbles
    load(8'h10);
    check("load_clears_expired", 32'(exp0), 32'd0);
    tick_expect(1'b0, 8'h09, "borrow_09");
    load(8'h1C);
    check("clamp_19", 32'(c0), 32'h19);

    // Pause drops ticks; resume decrements by exactly one
    pause = 1'b1;
    cycles(2);
    tick_expect(1'b0, 8'h19, "pause_hold_a");
    tick_expect(1'b0, 8'h19, "pause_hold_b");
    pause = 1'b0;
    cycles(2);
    tick_expect(1'b0, 8'h18, "resume_18");

    // Start_Timer in the same cycle as the tick wins
    value  = 8'h42;
    one_hz = 1'b1;
    cycles(2);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(4);
    one_hz = 1'b0;
    cycles(6);
    check("start_beats_tick", 32'(c0), 32'h42);
    tick_expect(1'b0, 8'h41, "after_prio_41");

    // Display scan with and without a blanked leading zero
    load(8'h07);
    scan("scan07");
    load(8'h42);
    scan("scan42");

    // Zero preload expires straight out of LOAD
    p0 = n_pul0;
    load(8'h00);
    check("zero_count",   32'(c0),          32'h00);
    check("zero_expired", 32'(exp0),        32'd1);
    check("zero_pulse",   32'(n_pul0 - p0), 32'd1);
    check("zero_running", 32'(run0),        32'd0);

    // Auto-reload instance
    p1 = n_pul1;
    load(8'h02);
    check("ar_load",    32'(c1),   32'h02);
    check("ar_running", 32'(run1), 32'd1);
    tick_expect(1'b1, 8'h01, "ar_01a");
    tick_expect(1'b1, 8'h02, "ar_02a");
    check("ar_run_a", 32'(run1), 32'd1);
    tick_expect(1'b1, 8'h01, "ar_01b");
    tick_expect(1'b1, 8'h02, "ar_02b");
    check("ar_run_b",   32'(run1),        32'd1);
    check("ar_pulses",  32'(n_pul1 - p1), 32'd2);
    check("ar_exp_lvl", 32'(exp1),        32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
